// File: rtl/wm_pkg.sv
// Shared state/phase encodings, data-field layout and actuator decode for the washer sequencer.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6
  } top_state_e;

  typedef enum logic [3:0] {
    PH_IDLE   = 4'd0,
    PH_WFILL  = 4'd1,
    PH_WASH   = 4'd2,
    PH_RDRAIN = 4'd3,
    PH_RSPIN  = 4'd4,
    PH_RFILL  = 4'd5,
    PH_RINSE  = 4'd6,
    PH_DDRAIN = 4'd7,
    PH_DSPIN  = 4'd8,
    PH_DONE   = 4'd9
  } phase_e;

  localparam int unsigned DATA_W  = 26;
  localparam int unsigned SHORT_W = 3;
  localparam int unsigned LONG_W  = 4;

  localparam int unsigned WFILL_LSB  = 23;
  localparam int unsigned WASH_LSB   = 19;
  localparam int unsigned RDRAIN_LSB = 16;
  localparam int unsigned RSPIN_LSB  = 13;
  localparam int unsigned RFILL_LSB  = 10;
  localparam int unsigned RINSE_LSB  = 6;
  localparam int unsigned DDRAIN_LSB = 3;
  localparam int unsigned DSPIN_LSB  = 0;

  function automatic logic [LONG_W-1:0] field_of(input logic [DATA_W-1:0] d, input phase_e p);
    logic [LONG_W-1:0] f;
    f = '0;
    case (p)
      PH_WFILL:  f = {1'b0, d[WFILL_LSB  +: SHORT_W]};
      PH_WASH:   f = d[WASH_LSB +: LONG_W];
      PH_RDRAIN: f = {1'b0, d[RDRAIN_LSB +: SHORT_W]};
      PH_RSPIN:  f = {1'b0, d[RSPIN_LSB  +: SHORT_W]};
      PH_RFILL:  f = {1'b0, d[RFILL_LSB  +: SHORT_W]};
      PH_RINSE:  f = d[RINSE_LSB +: LONG_W];
      PH_DDRAIN: f = {1'b0, d[DDRAIN_LSB +: SHORT_W]};
      PH_DSPIN:  f = {1'b0, d[DSPIN_LSB  +: SHORT_W]};
      default:   f = '0;
    endcase
    return f;
  endfunction

  // Returns {valve_in, motor_wash, valve_out, motor_spin}.
  function automatic logic [3:0] act_decode(input phase_e p);
    logic [3:0] a;
    a = '0;
    case (p)
      PH_WFILL, PH_RFILL:   a = 4'b1000;
      PH_WASH, PH_RINSE:    a = 4'b0100;
      PH_RDRAIN, PH_DDRAIN: a = 4'b0010;
      PH_RSPIN, PH_DSPIN:   a = 4'b0011;
      default:              a = 4'b0000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/wm_phase_sel.sv
// Finds the next phase after cur_i with a nonzero time field (or DONE) and that field's length.
module wm_phase_sel
  import wm_pkg::*;
#(
  parameter int unsigned LW = LONG_W
) (
  input  phase_e                  cur_i,
  input  logic [DATA_W-1:0]       data_i,
  output phase_e                  nxt_o,
  output logic [LW-1:0]           len_o
);

  // Scan from the last phase downward so the lowest qualifying phase wins.
  always_comb begin
    nxt_o = PH_DONE;
    len_o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (((8 - i) > 32'(cur_i)) && (field_of(data_i, phase_e'(4'(8 - i))) != '0)) begin
        nxt_o = phase_e'(4'(8 - i));
        len_o = LW'(field_of(data_i, phase_e'(4'(8 - i))));
      end
    end
  end

endmodule

// File: rtl/wash_sequencer.sv
// Timed wash-phase sequencer with registered actuator decode and programme countdown.
// Optional finish buzzer is built when WM_BUZZER_EN is defined.
module wash_sequencer
  import wm_pkg::*;
#(
  parameter int unsigned TW         = SHORT_W,
  parameter int unsigned LW         = LONG_W,
  parameter int unsigned RW         = 7,
  parameter int unsigned BUZZ_TICKS = 3
) (
  input  logic              cp,
  input  logic              rst_n,
  input  logic              tick_1s,
  input  logic [2:0]        state,
  input  logic [DATA_W-1:0] data,
  output logic              valve_in,
  output logic              motor_wash,
  output logic              valve_out,
  output logic              motor_spin,
  output logic [3:0]        phase,
  output logic [RW-1:0]     remain,
  output logic              done,
  output logic              buzzer
);

  top_state_e        st;
  phase_e            phase_q, phase_d, sel_nxt;
  logic [LW-1:0]     cnt_q, cnt_d, sel_len;
  logic [RW-1:0]     remain_q, remain_d, load_sum;
  logic [DATA_W-1:0] data_q, data_d, sel_data;
  logic              done_q, done_d;
  logic [3:0]        act_q, act_d;
  logic              abort;

  assign st    = top_state_e'(state);
  assign abort = (st == ST_SHUTDOWN) || (st == ST_BEGIN) || (st == ST_SET);

  // In IDLE the selector looks at live data so the first phase loads on the run edge.
  assign sel_data = (phase_q == PH_IDLE) ? data : data_q;

  assign load_sum = RW'(data[WFILL_LSB  +: TW]) + RW'(data[WASH_LSB  +: LW])
                  + RW'(data[RDRAIN_LSB +: TW]) + RW'(data[RSPIN_LSB +: TW])
                  + RW'(data[RFILL_LSB  +: TW]) + RW'(data[RINSE_LSB +: LW])
                  + RW'(data[DDRAIN_LSB +: TW]) + RW'(data[DSPIN_LSB +: TW]);

  wm_phase_sel #(.LW(LW)) u_sel (
    .cur_i  (phase_q),
    .data_i (sel_data),
    .nxt_o  (sel_nxt),
    .len_o  (sel_len)
  );

  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    remain_d = remain_q;
    data_d   = data_q;
    done_d   = 1'b0;
    case (st)
      ST_SHUTDOWN, ST_BEGIN, ST_SET: begin
        phase_d  = PH_IDLE;
        cnt_d    = '0;
        remain_d = '0;
      end
      ST_RUN: begin
        if (phase_q == PH_IDLE) begin
          data_d   = data;
          remain_d = load_sum;
          phase_d  = sel_nxt;
          cnt_d    = sel_len;
          done_d   = (sel_nxt == PH_DONE);
        end else if ((phase_q != PH_DONE) && tick_1s) begin
          remain_d = remain_q - RW'(1);
          if (cnt_q == LW'(1)) begin
            phase_d = sel_nxt;
            cnt_d   = sel_len;
            done_d  = (sel_nxt == PH_DONE);
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
      end
      default: ;
    endcase
    act_d = ((st == ST_ERROR) || (st == ST_PAUSE)) ? '0 : act_decode(phase_d);
  end

  always_ff @(posedge cp) begin
    if (!rst_n) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      remain_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      act_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      done_q   <= done_d;
      act_q    <= act_d;
    end
  end

  assign {valve_in, motor_wash, valve_out, motor_spin} = act_q;
  assign phase  = phase_q;
  assign remain = remain_q;
  assign done   = done_q;

`ifdef WM_BUZZER_EN
  localparam int unsigned BW = $clog2(BUZZ_TICKS + 1);

  logic          buzz_q, buzz_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    buzz_d = buzz_q;
    bcnt_d = bcnt_q;
    if (abort) begin
      buzz_d = 1'b0;
      bcnt_d = '0;
    end else if (done_q) begin
      buzz_d = 1'b1;
      bcnt_d = BW'(BUZZ_TICKS);
    end else if (buzz_q && tick_1s) begin
      if (bcnt_q <= BW'(1)) begin
        buzz_d = 1'b0;
        bcnt_d = '0;
      end else begin
        bcnt_d = bcnt_q - BW'(1);
      end
    end
  end

  always_ff @(posedge cp) begin
    if (!rst_n) begin
      buzz_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      buzz_q <= buzz_d;
      bcnt_q <= bcnt_d;
    end
  end

  // Gated by abort so a return to shutDown/begin/set silences it in the same cycle.
  assign buzzer = buzz_q & ~abort;
`else
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench: directed scenarios plus randomized runs against a time-elapsed programme model.
module tb_wash_sequencer;

  logic        cp = 1'b0;
  logic        rst_n, tick_1s;
  logic [2:0]  state;
  logic [25:0] data;
  logic        valve_in, motor_wash, valve_out, motor_spin, done, buzzer;
  logic [3:0]  phase;
  logic [6:0]  remain;

  wash_sequencer #(.TW(3), .LW(4), .RW(7), .BUZZ_TICKS(3)) dut (
    .cp(cp), .rst_n(rst_n), .tick_1s(tick_1s), .state(state), .data(data),
    .valve_in(valve_in), .motor_wash(motor_wash), .valve_out(valve_out),
    .motor_spin(motor_spin), .phase(phase), .remain(remain), .done(done), .buzzer(buzzer)
  );

  always #5 cp = ~cp;

  localparam logic [25:0] DEF  = 26'b011_1010_100_101_011_1000_100_101;
  localparam logic [25:0] WASH = {3'b011, 4'b1010, 19'd0};

  int n_cmp = 0, n_bad = 0;

  // Model: programme is described by its field list and elapsed seconds.
  int m_mode = 0;          // 0 idle, 1 running, 2 done
  int m_fld[8];
  int m_total = 0, m_elapsed = 0;
  bit m_done = 0, m_buzz = 0;
  int m_left = 0;
  int fw[8] = '{3, 4, 3, 3, 3, 4, 3, 3};

  int tick_cnt, valve_ticks, done_cnt, buzz_ticks, last_ph;
  int seen[$];
  int exp_w[3] = '{1, 2, 9};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic void model_update(bit r, logic [2:0] s, bit t, logic [25:0] d);
    bit done_prev;
    int pos;
    done_prev = m_done;
    m_done = 1'b0;
    if (!r) begin
      m_mode = 0; m_elapsed = 0; m_total = 0; m_buzz = 0; m_left = 0;
      foreach (m_fld[i]) m_fld[i] = 0;
      return;
    end
    if (s <= 3'd2) begin
      m_mode = 0; m_elapsed = 0; m_buzz = 0; m_left = 0;
      return;
    end
    if (s == 3'd3) begin
      if (m_mode == 0) begin
        pos = 26; m_total = 0;
        for (int i = 0; i < 8; i++) begin
          pos -= fw[i];
          m_fld[i] = int'((d >> pos) & ((26'd1 << fw[i]) - 26'd1));
          m_total += m_fld[i];
        end
        m_elapsed = 0;
        if (m_total == 0) begin m_mode = 2; m_done = 1'b1; end
        else m_mode = 1;
      end else if (m_mode == 1 && t) begin
        m_elapsed++;
        if (m_elapsed == m_total) begin m_mode = 2; m_done = 1'b1; end
      end
    end
    if (done_prev) begin
      m_buzz = 1'b1; m_left = 3;
    end else if (m_buzz && t) begin
      m_left--;
      if (m_left == 0) m_buzz = 1'b0;
    end
  endfunction

  function automatic int exp_phase();
    int cum;
    cum = 0;
    if (m_mode == 0) return 0;
    if (m_mode == 2) return 9;
    for (int i = 0; i < 8; i++) begin
      cum += m_fld[i];
      if (cum > m_elapsed) return i + 1;
    end
    return 9;
  endfunction

  function automatic logic [3:0] exp_act(int p, logic [2:0] s);
    if (s == 3'd4 || s == 3'd5) return 4'b0000;
    if (p == 1 || p == 5) return 4'b1000;
    if (p == 2 || p == 6) return 4'b0100;
    if (p == 3 || p == 7) return 4'b0010;
    if (p == 4 || p == 8) return 4'b0011;
    return 4'b0000;
  endfunction

  task automatic step(input bit r, input logic [2:0] s, input bit t, input logic [25:0] d);
    int ep;
    logic [3:0] ea;
    rst_n = r; state = s; tick_1s = t; data = d;
    #1;
    if (t && r && s == 3'd3 && phase >= 4'd1 && phase <= 4'd8) tick_cnt++;
    if (t && valve_in) valve_ticks++;
    if (t && buzzer) buzz_ticks++;
    @(posedge cp);
    model_update(r, s, t, d);
    #1;
    if (done) done_cnt++;
    if (int'(phase) != last_ph) begin seen.push_back(int'(phase)); last_ph = int'(phase); end
    ep = exp_phase();
    ea = r ? exp_act(ep, s) : 4'b0000;
    chk("phase", phase, ep);
    chk("remain", remain, (m_mode == 1) ? (m_total - m_elapsed) : 0);
    chk("done", done, m_done);
    chk("valve_in", valve_in, ea[3]);
    chk("motor_wash", motor_wash, ea[2]);
    chk("valve_out", valve_out, ea[1]);
    chk("motor_spin", motor_spin, ea[0]);
`ifdef WM_BUZZER_EN
    chk("buzzer", buzzer, m_buzz);
`else
    chk("buzzer", buzzer, 0);
`endif
  endtask

  task automatic clear_stats();
    tick_cnt = 0; valve_ticks = 0; done_cnt = 0; buzz_ticks = 0;
    seen.delete(); last_ph = int'(phase);
  endtask

  // kind 0: wait for phase==val, kind 1: wait for remain==val; data after the load is random junk.
  task automatic run_until(input string tag, input int kind, input int val, input logic [25:0] prog, input int budget);
    int n;
    n = 0;
    while (!((kind == 0 && int'(phase) == val) || (kind == 1 && int'(remain) == val)) && n < budget) begin
      step(1'b1, 3'd3, 1'($urandom_range(0, 1)), (m_mode == 0) ? prog : 26'($urandom));
      n++;
    end
    chk(tag, (kind == 0) ? 32'(phase) : 32'(remain), val);
  endtask

  initial begin
    int r;
    logic [2:0] s;
    logic [25:0] rd;
    rst_n = 1'b0; state = 3'd0; tick_1s = 1'b0; data = '0;
    tick_cnt = 0; valve_ticks = 0; done_cnt = 0; buzz_ticks = 0; last_ph = 0;

    step(1'b0, 3'd3, 1'b1, DEF);
    step(1'b0, 3'd0, 1'b0, DEF);

    // Default programme.
    step(1'b1, 3'd2, 1'b0, DEF);
    clear_stats();
    step(1'b1, 3'd3, 1'b1, DEF);
    chk("dflt_load_remain", remain, 42);
    run_until("dflt_reach_done", 0, 9, DEF, 400);
    chk("dflt_ticks", tick_cnt, 42);
    chk("dflt_valve_in_ticks", valve_ticks, 6);
    chk("dflt_done_pulses", done_cnt, 1);
    chk("dflt_nphases", seen.size(), 9);
    for (int i = 0; i < 9 && i < seen.size(); i++) chk("dflt_seq", seen[i], i + 1);
    repeat (8) step(1'b1, 3'd3, 1'b1, 26'($urandom));
`ifdef WM_BUZZER_EN
    chk("buzz_ticks", buzz_ticks, 3);
`else
    chk("buzz_ticks", buzz_ticks, 0);
`endif
    repeat (4) step(1'b1, 3'd6, 1'b1, 26'($urandom));
    chk("finish_hold", phase, 9);

    // Wash-only programme.
    step(1'b1, 3'd2, 1'b0, WASH);
    clear_stats();
    step(1'b1, 3'd3, 1'b0, WASH);
    run_until("wash_reach_done", 0, 9, WASH, 200);
    chk("wash_ticks", tick_cnt, 13);
    chk("wash_nphases", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++) chk("wash_seq", seen[i], exp_w[i]);

    // All-zero programme.
    step(1'b1, 3'd1, 1'b0, '0);
    step(1'b1, 3'd3, 1'b0, '0);
    chk("zero_done", done, 1);
    chk("zero_phase", phase, 9);
    repeat (5) step(1'b1, 3'd3, 1'b1, 26'($urandom));

    // Pause and resume.
    step(1'b1, 3'd2, 1'b0, DEF);
    step(1'b1, 3'd3, 1'b0, DEF);
    run_until("reach_remain30", 1, 30, DEF, 200);
    repeat (20) step(1'b1, 3'd5, 1'b1, 26'($urandom));
    chk("pause_remain", remain, 30);
    chk("pause_phase", phase, 2);
    chk("pause_act", {valve_in, motor_wash, valve_out, motor_spin}, 0);
    step(1'b1, 3'd3, 1'b1, 26'($urandom));
    chk("resume_remain", remain, 29);
    repeat (6) step(1'b1, 3'd4, 1'b1, 26'($urandom));
    chk("error_remain", remain, 29);

    // Abort mid phase 4, then rerun.
    run_until("reach_ph4", 0, 4, DEF, 300);
    step(1'b1, 3'd2, 1'b1, 26'($urandom));
    chk("abort_phase", phase, 0);
    chk("abort_remain", remain, 0);
    step(1'b1, 3'd3, 1'b0, DEF);
    chk("rerun_remain", remain, 42);

    // Reset during phase 6.
    run_until("reach_ph6", 0, 6, DEF, 300);
    step(1'b0, 3'd3, 1'b1, DEF);
    chk("rst_mid_phase", phase, 0);
    chk("rst_mid_act", {valve_in, motor_wash, valve_out, motor_spin, done, buzzer}, 0);

    // Randomized programmes with random state excursions.
    for (int k = 0; k < 6; k++) begin
      rd = 26'($urandom);
      step(1'b1, 3'd2, 1'b0, rd);
      for (int n = 0; n < 600 && m_mode != 2; n++) begin
        r = $urandom_range(0, 99);
        s = (r < 80) ? 3'd3 : (r < 88) ? 3'd5 : (r < 94) ? 3'd4 : (r < 99) ? 3'd6 : 3'd2;
        step(1'b1, s, 1'($urandom_range(0, 1)), (m_mode == 0) ? rd : 26'($urandom));
      end
      repeat (6) step(1'b1, 3'($urandom_range(3, 6)), 1'b1, 26'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
